// File: rtl/mem_buffer_reducer.sv
// Strided buffer reduction engine (sum/xor/max/min) with a single-line read cache.
// Optional perf counters are built only when REDUCER_PERF_EN is defined.
module mem_buffer_reducer #(
    parameter int WORD_WIDTH  = 32,
    parameter int LINE_WORDS  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start_i,
    input  logic [1:0]                       mode_i,
    input  logic [ADDR_WIDTH-1:0]            base_i,
    input  logic [COUNT_WIDTH-1:0]           count_i,
    input  logic [COUNT_WIDTH-1:0]           stride_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [ACC_WIDTH-1:0]             result_o,
    output logic                             mem_req_valid_o,
    input  logic                             mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr_o,
    input  logic                             mem_rsp_valid_i,
    input  logic [LINE_WORDS*WORD_WIDTH-1:0] mem_rsp_data_i,
    output logic [31:0]                      perf_cycles_o,
    output logic [15:0]                      perf_fetches_o
);

    localparam int BYTES = WORD_WIDTH / 8;
    localparam int WSH   = $clog2(BYTES);
    localparam int OFF   = $clog2(LINE_WORDS * BYTES);
    localparam int TAG_W = ADDR_WIDTH - OFF;
    localparam int IDX_W = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                          state_q;
    logic [1:0]                      mode_q;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [ADDR_WIDTH-1:0]           step_q;
    logic [COUNT_WIDTH-1:0]          remain_q;
    logic [ACC_WIDTH-1:0]            acc_q;
    logic [ACC_WIDTH-1:0]            result_q;
    logic                            done_q;
    logic                            req_valid_q;
    logic [ADDR_WIDTH-1:0]           req_addr_q;
    logic [LINE_WORDS*WORD_WIDTH-1:0] line_q;
    logic [TAG_W-1:0]                tag_q;
    logic                            line_valid_q;

    logic [TAG_W-1:0]                elem_tag;
    logic [IDX_W-1:0]                word_sel;
    logic [WORD_WIDTH-1:0]           word;
    logic [ACC_WIDTH-1:0]            word_ext;
    logic [ACC_WIDTH-1:0]            acc_d;
    logic [ACC_WIDTH-1:0]            preload;
    logic [COUNT_WIDTH-1:0]          stride_eff;
    logic                            hit;

    assign elem_tag   = addr_q[ADDR_WIDTH-1:OFF];
    assign word_sel   = addr_q[OFF-1:WSH];
    assign hit        = line_valid_q && (tag_q == elem_tag);
    assign preload    = (mode_i == 2'd3) ? '1 : '0;
    assign stride_eff = (stride_i == '0) ? COUNT_WIDTH'(1) : stride_i;
    assign word_ext   = ACC_WIDTH'(word);

    always_comb begin
        word = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (word_sel == IDX_W'(k)) word = line_q[k*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    always_comb begin
        acc_d = acc_q;
        case (mode_q)
            2'd0: acc_d = acc_q + word_ext;
            2'd1: acc_d = acc_q ^ word_ext;
            2'd2: acc_d = (word_ext > acc_q) ? word_ext : acc_q;
            2'd3: acc_d = (word_ext < acc_q) ? word_ext : acc_q;
            default: acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            addr_q       <= '0;
            step_q       <= '0;
            remain_q     <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            line_q       <= '0;
            tag_q        <= '0;
            line_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q       <= mode_i;
                        addr_q       <= {base_i[ADDR_WIDTH-1:WSH], {WSH{1'b0}}};
                        step_q       <= ADDR_WIDTH'(stride_eff) << WSH;
                        remain_q     <= count_i;
                        acc_q        <= preload;
                        line_valid_q <= 1'b0;
                        if (count_i == '0) begin
                            result_q <= preload;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (hit) begin
                        acc_q    <= acc_d;
                        addr_q   <= addr_q + step_q;
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == COUNT_WIDTH'(1)) begin
                            result_q <= acc_d;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end else begin
                        req_valid_q <= 1'b1;
                        req_addr_q  <= {elem_tag, {OFF{1'b0}}};
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        line_q       <= mem_rsp_data_i;
                        tag_q        <= req_addr_q[ADDR_WIDTH-1:OFF];
                        line_valid_q <= 1'b1;
                        state_q      <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
    assign result_o        = result_q;
    assign mem_req_valid_o = req_valid_q;
    assign mem_req_addr_o  = req_addr_q;

`ifdef REDUCER_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [15:0] perf_fetches_q;

    // Counters restart on an accepted start and freeze once the FSM returns to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cycles_q  <= '0;
            perf_fetches_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            perf_cycles_q  <= '0;
            perf_fetches_q <= '0;
        end else begin
            if (state_q != S_IDLE) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (state_q == S_REQ && mem_req_ready_i) perf_fetches_q <= perf_fetches_q + 16'd1;
        end
    end

    assign perf_cycles_o  = perf_cycles_q;
    assign perf_fetches_o = perf_fetches_q;
`else
    assign perf_cycles_o  = '0;
    assign perf_fetches_o = '0;
`endif

endmodule

// File: tb/tb_mem_buffer_reducer.sv
// Self-checking bench for mem_buffer_reducer: line memory model plus result scoreboard.
module tb_mem_buffer_reducer;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = '0;
    logic [31:0]   base_i = '0;
    logic [15:0]   count_i = '0;
    logic [15:0]   stride_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [31:0]   result_o;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i = 1'b1;
    logic [31:0]   mem_req_addr_o;
    logic          mem_rsp_valid_i = 1'b0;
    logic [127:0]  mem_rsp_data_i = '0;
    logic [31:0]   perf_cycles_o;
    logic [15:0]   perf_fetches_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    bit          hold_ready = 1'b0;
    int          pend = 0;
    logic [31:0] pend_addr = '0;
    int          fetch_seen = 0;
    int          req_cycles = 0;

    mem_buffer_reducer dut (
        .clock(clock), .reset(reset), .start_i(start_i), .mode_i(mode_i),
        .base_i(base_i), .count_i(count_i), .stride_i(stride_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i(mem_rsp_data_i), .perf_cycles_o(perf_cycles_o),
        .perf_fetches_o(perf_fetches_o)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] d;
        d = a - 32'h1800;
        return d >> 2;
    endfunction

    // Memory model: response lands two cycles after the accepting edge.
    always @(negedge clock) begin
        mem_rsp_valid_i = 1'b0;
        mem_req_ready_i = !hold_ready;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_rsp_valid_i = 1'b1;
                for (int k = 0; k < 4; k++) mem_rsp_data_i[k*32 +: 32] = memword(pend_addr + 32'(4*k));
            end
        end
        if (mem_req_valid_o) req_cycles++;
        if (mem_req_valid_o && mem_req_ready_i) begin
            pend = 2;
            pend_addr = mem_req_addr_o;
            fetch_seen++;
        end
    end

    function automatic logic [31:0] ref_result(input logic [1:0] m, input logic [31:0] b,
                                               input logic [15:0] c, input logic [15:0] s);
        logic [31:0] acc, a, w, st;
        st  = (s == 0) ? 32'd1 : 32'(s);
        acc = (m == 2'd3) ? 32'hFFFF_FFFF : 32'd0;
        for (int i = 0; i < int'(c); i++) begin
            a = (b & ~32'h3) + 32'(i) * st * 32'd4;
            w = memword(a);
            case (m)
                2'd0: acc = acc + w;
                2'd1: acc = acc ^ w;
                2'd2: if (w > acc) acc = w;
                default: if (w < acc) acc = w;
            endcase
        end
        return acc;
    endfunction

    function automatic int ref_fetches(input logic [31:0] b, input logic [15:0] c, input logic [15:0] s);
        logic [31:0] a, st, line, prev;
        int n;
        bit have;
        n = 0; have = 0; prev = '0;
        st = (s == 0) ? 32'd1 : 32'(s);
        for (int i = 0; i < int'(c); i++) begin
            a = (b & ~32'h3) + 32'(i) * st * 32'd4;
            line = a & ~32'hF;
            if (!have || line != prev) n++;
            have = 1; prev = line;
        end
        return n;
    endfunction

    task automatic start_op(input logic [1:0] m, input logic [31:0] b, input logic [15:0] c,
                            input logic [15:0] s);
        @(negedge clock);
        mode_i = m; base_i = b; count_i = c; stride_i = s; start_i = 1'b1;
        exp_q.push_back(ref_result(m, b, c, s));
        @(negedge clock);
        start_i = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done_o) begin ok = 1; break; end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0h exp 0", done_o); end
        checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result got %0h exp 0", result_o); end
        checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0h exp 0", mem_req_valid_o); end
        checks++; if (mem_req_addr_o !== 32'd0) begin errors++; $display("FAIL reset_req_addr got %0h exp 0", mem_req_addr_o); end
        checks++; if (perf_cycles_o !== 32'd0) begin errors++; $display("FAIL reset_perf_cycles got %0d exp 0", perf_cycles_o); end
        checks++; if (perf_fetches_o !== 16'd0) begin errors++; $display("FAIL reset_perf_fetches got %0d exp 0", perf_fetches_o); end
    endtask

    task automatic test_sum(input logic [15:0] c, input logic [15:0] s, input string tag);
        bit ok;
        int f0, fexp;
        logic [31:0] e;
        f0 = fetch_seen;
        fexp = ref_fetches(32'h1800, c, s);
        start_op(2'd0, 32'h1800, c, s);
        wait_done(ok);
        e = exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL %s_done_timeout got 0 exp 1", tag); end
        checks++; if (result_o !== e) begin errors++; $display("FAIL %s_result got %0d exp %0d", tag, result_o, e); end
        checks++; if (fetch_seen - f0 != fexp) begin errors++; $display("FAIL %s_bus_fetches got %0d exp %0d", tag, fetch_seen - f0, fexp); end
`ifdef REDUCER_PERF_EN
        checks++; if (perf_fetches_o !== 16'(fexp)) begin errors++; $display("FAIL %s_perf_fetches got %0d exp %0d", tag, perf_fetches_o, fexp); end
`else
        checks++; if (perf_cycles_o !== 32'd0) begin errors++; $display("FAIL %s_perf_cycles got %0d exp 0", tag, perf_cycles_o); end
`endif
        @(negedge clock);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %0b%0b exp 00", tag, done_o, busy_o); end
    endtask

    task automatic test_modes();
        bit ok;
        logic [31:0] e;
        logic [1:0]  ml[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        logic [15:0] cl[4] = '{16'd16, 16'd16, 16'd16, 16'd0};
        for (int i = 0; i < 4; i++) begin
            start_op(ml[i], 32'h1800, cl[i], 16'd1);
            wait_done(ok);
            e = exp_q.pop_front();
            checks++; if (!ok) begin errors++; $display("FAIL mode%0d_timeout got 0 exp 1", i); end
            checks++; if (result_o !== e) begin errors++; $display("FAIL mode%0d_result got %0h exp %0h", i, result_o, e); end
            @(negedge clock);
        end
    endtask

    task automatic test_zero_count();
        int r0;
        logic [31:0] e;
        r0 = req_cycles;
        start_op(2'd0, 32'h1800, 16'd0, 16'd1);
        e = exp_q.pop_front();
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL zero_done_latency got %0b exp 1", done_o); end
        checks++; if (result_o !== e) begin errors++; $display("FAIL zero_result got %0h exp %0h", result_o, e); end
`ifdef REDUCER_PERF_EN
        @(negedge clock);
        checks++; if (perf_cycles_o !== 32'd1) begin errors++; $display("FAIL zero_perf_cycles got %0d exp 1", perf_cycles_o); end
`else
        @(negedge clock);
`endif
        repeat (3) @(negedge clock);
        checks++; if (req_cycles != r0) begin errors++; $display("FAIL zero_no_req got %0d exp 0", req_cycles - r0); end
    endtask

    task automatic test_back_to_back();
        bit ok, seen;
        logic [31:0] e;
        hold_ready = 1'b1;
        start_op(2'd0, 32'h1800, 16'd16, 16'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid_o) begin seen = 1; break; end
            @(negedge clock);
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_req_timeout got 0 exp 1"); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin mode_i = 2'd3; count_i = 16'd0; start_i = 1'b1; end
            else start_i = 1'b0;
            checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_stable got %0b exp 1", mem_req_valid_o); end
            checks++; if (mem_req_addr_o !== 32'h1800) begin errors++; $display("FAIL bp_addr_stable got %0h exp 1800", mem_req_addr_o); end
            @(negedge clock);
        end
        start_i = 1'b0;
        hold_ready = 1'b0;
        wait_done(ok);
        e = exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got 0 exp 1"); end
        checks++; if (result_o !== e) begin errors++; $display("FAIL bp_result got %0d exp %0d", result_o, e); end
        seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (done_o) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL bp_extra_done got 1 exp 0"); end
    endtask

    task automatic test_reset_in_wait();
        bit ok, acc;
        logic [31:0] e;
        start_op(2'd0, 32'h1800, 16'd16, 16'd1);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid_o && mem_req_ready_i) begin acc = 1; break; end
            @(negedge clock);
        end
        checks++; if (!acc) begin errors++; $display("FAIL rw_accept_timeout got 0 exp 1"); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rw_busy got %0b exp 0", busy_o); end
        checks++; if (done_o !== 1'b0 || result_o !== 32'd0) begin errors++; $display("FAIL rw_done_result got %0b/%0h exp 0/0", done_o, result_o); end
        checks++; if (mem_req_valid_o !== 1'b0 || mem_req_addr_o !== 32'd0) begin errors++; $display("FAIL rw_req got %0b/%0h exp 0/0", mem_req_valid_o, mem_req_addr_o); end
        checks++; if (perf_cycles_o !== 32'd0 || perf_fetches_o !== 16'd0) begin errors++; $display("FAIL rw_perf got %0d/%0d exp 0/0", perf_cycles_o, perf_fetches_o); end
        repeat (3) @(negedge clock);
        start_op(2'd0, 32'h1800, 16'd4, 16'd1);
        wait_done(ok);
        e = exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL rw_new_timeout got 0 exp 1"); end
        checks++; if (result_o !== e || e !== 32'd6) begin errors++; $display("FAIL rw_new_result got %0d exp 6", result_o); end
    endtask

    initial begin
        test_reset();
        test_sum(16'd16, 16'd1, "sum_s1");
        test_sum(16'd8, 16'd2, "sum_s2");
        test_sum(16'd6, 16'd0, "sum_s0");
        test_sum(16'd5, 16'd4, "sum_s4");
        test_modes();
        test_zero_count();
        test_back_to_back();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
